// File: rtl/obf_seq.sv
// obf_seq: expands an accepted instruction into a LUT-driven sequence of substitution beats
`ifndef OBF_IGU_WIDTH
`define OBF_IGU_WIDTH 7
`endif
`ifndef OBF_SUB_WIDTH
`define OBF_SUB_WIDTH 4
`endif
`ifndef OBF_INSN_TYPE_N
`define OBF_INSN_TYPE_N 3'd0
`endif
module obf_seq #(
  parameter int IGU_W  = `OBF_IGU_WIDTH,
  parameter int SUB_W  = `OBF_SUB_WIDTH,
  parameter int TYPE_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   insn_valid,
  input  logic [31:0]            insn_in,
  input  logic [IGU_W-1:0]       igu_id,
  output logic                   insn_ready,
  output logic [IGU_W+SUB_W-1:0] lut_addr,
  input  logic [TYPE_W+16:0]     lut_out,
  output logic                   sub_valid,
  output logic [TYPE_W-1:0]      sub_type,
  output logic [15:0]            sub_fields,
  output logic                   sub_last,
  output logic [31:0]            sub_insn,
  input  logic                   sub_ready,
  output logic                   obf_err
);
  typedef enum logic {IDLE, SEQ} state_t;
  localparam logic [TYPE_W-1:0] TYPE_N = TYPE_W'(`OBF_INSN_TYPE_N);
  state_t           state, state_n;
  logic [IGU_W-1:0] igu_q;
  logic [SUB_W-1:0] sub_q;
  logic             free, accept, lut_last, wrap, load_seq;
  assign lut_addr = {igu_q, sub_q};
  always_comb begin
    free       = !sub_valid || sub_ready;
    insn_ready = (state == IDLE) && free;
    accept     = insn_valid && insn_ready;
    lut_last   = lut_out[0];
    // last index reached without a terminating entry: end the sequence rather than wrap
    wrap       = (sub_q == '1) && !lut_last;
    load_seq   = (state == SEQ) && free;
    state_n    = flush ? IDLE :
                 (accept && |igu_id) ? SEQ :
                 (load_seq && (lut_last || wrap)) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      igu_q      <= '0;
      sub_q      <= '0;
      sub_valid  <= 1'b0;
      sub_type   <= '0;
      sub_fields <= '0;
      sub_last   <= 1'b0;
      sub_insn   <= '0;
      obf_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (flush) begin
        sub_q     <= '0;
        sub_valid <= 1'b0;
      end else if (accept) begin
        sub_insn <= insn_in;
        if (|igu_id) begin
          igu_q     <= igu_id;
          sub_q     <= '0;
          sub_valid <= 1'b0;
        end else begin
          sub_valid  <= 1'b1;
          sub_type   <= TYPE_N;
          sub_fields <= '0;
          sub_last   <= 1'b1;
        end
      end else if (load_seq) begin
        sub_valid  <= 1'b1;
        sub_type   <= lut_out[TYPE_W+16:17];
        sub_fields <= lut_out[16:1];
        sub_last   <= lut_last || wrap;
        if (wrap) obf_err <= 1'b1;
        else if (!lut_last) sub_q <= sub_q + SUB_W'(1);
      end else if (sub_ready) begin
        sub_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_obf_seq.sv
// tb_obf_seq: directed and randomized checks of obf_seq against a beat-queue reference model
module tb_obf_seq;
  localparam logic [2:0] T_N = 3'd0, T_I = 3'd1, T_A = 3'd2;
  logic        clk = 1'b0, rst, flush, insn_valid, insn_ready, sub_valid, sub_last, sub_ready, obf_err;
  logic [31:0] insn_in, sub_insn;
  logic [6:0]  igu_id;
  logic [10:0] lut_addr;
  logic [19:0] lut_out;
  logic [2:0]  sub_type;
  logic [15:0] sub_fields;
  int          mode = 0, checks = 0, errors = 0, fires = 0;
  logic        exp_err = 1'b0;
  logic [51:0] q[$];
  obf_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .insn_valid(insn_valid), .insn_in(insn_in),
    .igu_id(igu_id), .insn_ready(insn_ready), .lut_addr(lut_addr), .lut_out(lut_out),
    .sub_valid(sub_valid), .sub_type(sub_type), .sub_fields(sub_fields), .sub_last(sub_last),
    .sub_insn(sub_insn), .sub_ready(sub_ready), .obf_err(obf_err)
  );
  always #5 clk = ~clk;
  // LUT stub: mode 0 = reference table, 1 = never terminates, 2 = synthetic table for random runs
  function automatic logic [19:0] lut_f(input int m, input logic [6:0] g, input logic [3:0] k);
    int len;
    if (m == 0) begin
      if (g == 7'd64 && k == 4'd0) return {T_I, 16'h9E80, 1'b0};
      if (g == 7'd64 && k == 4'd1) return {T_A, 16'h0140, 1'b0};
      if (g == 7'd64 && k == 4'd2) return {T_A, 16'h05E0, 1'b1};
      return {T_N, 16'h0, 1'b1};
    end
    if (m == 1) return {T_I, 12'h0, k, 1'b0};
    if (g % 13 == 0) return {T_A, 5'h0, g, k, 1'b0};
    len = g % 7;
    if (int'(k) < len) return {3'(g + 7'(k)), 5'h0, g, k, int'(k) == len - 1};
    return {T_N, 16'h0, 1'b1};
  endfunction
  assign lut_out = lut_f(mode, lut_addr[10:4], lut_addr[3:0]);
  task automatic push_seq(input logic [6:0] g, input logic [31:0] ins);
    logic [19:0] w;
    logic        l, done;
    if (g == 0) q.push_back({T_N, 16'h0, 1'b1, ins});
    else begin
      done = 1'b0;
      for (int k = 0; k < 16 && !done; k++) begin
        w = lut_f(mode, g, 4'(k));
        l = w[0] || k == 15;
        q.push_back({w[19:1], l, ins});
        if (l && !w[0]) exp_err = 1'b1;
        done = l;
      end
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic fire, acc;
    #1;
    fire = sub_valid && sub_ready;
    acc  = insn_valid && insn_ready;
    if (sub_valid === 1'b1) begin
      if (q.size() == 0) chk("beat_unexpected", 64'(sub_valid), 64'd0);
      else chk("beat", {sub_type, sub_fields, sub_last, sub_insn}, q[0]);
    end
    @(posedge clk);
    if (fire === 1'b1) fires++;
    if (!rst) begin
      q.delete();
      exp_err = 1'b0;
    end else if (flush) q.delete();
    else begin
      if (fire === 1'b1 && q.size() > 0) void'(q.pop_front());
      if (acc === 1'b1) push_seq(igu_id, insn_in);
    end
    @(negedge clk);
  endtask
  task automatic offer(input logic [6:0] g, input logic [31:0] ins);
    insn_valid = 1'b1;
    igu_id     = g;
    insn_in    = ins;
    tick();
    insn_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b0; flush = 1'b0; insn_valid = 1'b0; insn_in = '0; igu_id = '0; sub_ready = 1'b1;
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(sub_valid), 64'd0);
    chk("rst_slot", {sub_type, sub_fields, sub_last, sub_insn}, 64'd0);
    chk("rst_err", 64'(obf_err), 64'd0);
    chk("rst_ready", 64'(insn_ready), 64'd1);
    chk("rst_addr", 64'(lut_addr), 64'd0);
    offer(7'd64, 32'hE0632000);
    chk("s35_gap", 64'(sub_valid), 64'd0);
    chk("s35_a0", 64'(lut_addr), {7'd64, 4'd0});
    tick();
    chk("s35_b1", {sub_valid, sub_type, sub_fields, sub_last}, {1'b1, T_I, 16'h9E80, 1'b0});
    chk("s35_a1", 64'(lut_addr), {7'd64, 4'd1});
    chk("s35_busy1", 64'(insn_ready), 64'd0);
    tick();
    chk("s35_b2", {sub_valid, sub_type, sub_fields, sub_last}, {1'b1, T_A, 16'h0140, 1'b0});
    chk("s35_a2", 64'(lut_addr), {7'd64, 4'd2});
    chk("s35_busy2", 64'(insn_ready), 64'd0);
    tick();
    chk("s35_b3", {sub_valid, sub_type, sub_fields, sub_last}, {1'b1, T_A, 16'h05E0, 1'b1});
    chk("s35_insn", 64'(sub_insn), 64'hE0632000);
    chk("s35_rdy", 64'(insn_ready), 64'd1);
    tick();
    chk("s35_done", 64'(sub_valid), 64'd0);
    offer(7'd0, 32'h15000000);
    chk("s36_beat", {sub_valid, sub_type, sub_fields, sub_last, sub_insn}, {1'b1, T_N, 16'h0, 1'b1, 32'h15000000});
    chk("s36_addr", 64'(lut_addr), {7'd64, 4'd2});
    tick();
    chk("s36_done", 64'(sub_valid), 64'd0);
    offer(7'd64, 32'hE0632000);
    tick();
    sub_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("s37_hold", {sub_valid, sub_type, sub_fields, sub_last}, {1'b1, T_I, 16'h9E80, 1'b0});
      chk("s37_addr", 64'(lut_addr), {7'd64, 4'd1});
      tick();
    end
    sub_ready = 1'b1;
    tick();
    chk("s37_b2", {sub_valid, sub_type, sub_fields, sub_last}, {1'b1, T_A, 16'h0140, 1'b0});
    repeat (2) tick();
    chk("s37_done", 64'(sub_valid), 64'd0);
    chk("s37_q", 64'(q.size()), 64'd0);
    offer(7'd5, 32'h12345678);
    sub_ready = 1'b0;
    tick();
    chk("s38_beat", {sub_valid, sub_type, sub_fields, sub_last}, {1'b1, T_N, 16'h0, 1'b1});
    chk("s38_busy", 64'(insn_ready), 64'd0);
    sub_ready = 1'b1;
    tick();
    chk("s38_ready", 64'(insn_ready), 64'd1);
    chk("s38_empty", 64'(sub_valid), 64'd0);
    mode = 1;
    fires = 0;
    offer(7'd64, 32'hCAFE0001);
    repeat (24) tick();
    chk("s39_count", 64'(fires), 64'd16);
    chk("s39_err", 64'(obf_err), 64'd1);
    chk("s39_q", 64'(q.size()), 64'd0);
    offer(7'd0, 32'h0BADF00D);
    tick();
    chk("s39_sticky", 64'(obf_err), 64'd1);
    mode = 0;
    offer(7'd64, 32'hE0632000);
    tick();
    chk("s40_b1", 64'(sub_type), 64'(T_I));
    flush = 1'b1; insn_valid = 1'b1; igu_id = 7'd0; sub_ready = 1'b0;
    tick();
    flush = 1'b0; insn_valid = 1'b0; sub_ready = 1'b1;
    #1;
    chk("flush_valid", 64'(sub_valid), 64'd0);
    chk("flush_ready", 64'(insn_ready), 64'd1);
    chk("flush_err", 64'(obf_err), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_quiet", 64'(sub_valid), 64'd0);
    end
    offer(7'd64, 32'hE0632000);
    tick();
    rst = 1'b0; insn_valid = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b1; insn_valid = 1'b0; flush = 1'b0;
    #1;
    chk("rst40_valid", 64'(sub_valid), 64'd0);
    chk("rst40_ready", 64'(insn_ready), 64'd1);
    chk("rst40_err", 64'(obf_err), 64'd0);
    chk("rst40_addr", 64'(lut_addr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst40_quiet", 64'(sub_valid), 64'd0);
    end
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      insn_valid = 1'($urandom % 2);
      insn_in    = $urandom;
      igu_id     = ($urandom % 4 == 0) ? 7'd0 : 7'($urandom_range(1, 30));
      sub_ready  = ($urandom % 10) < 7;
      flush      = ($urandom % 60) == 0;
      tick();
    end
    flush = 1'b0; insn_valid = 1'b0; sub_ready = 1'b1;
    repeat (60) tick();
    chk("rnd_q", 64'(q.size()), 64'd0);
    chk("rnd_valid", 64'(sub_valid), 64'd0);
    chk("rnd_err", 64'(obf_err), 64'(exp_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
